dmg_lcd_rx: RTL and testbench
=============================

Name: dmg_lcd_rx

Overview:
Receiver for the DMG LCD panel bus (d0/d1/hsync/vsync/datal/altsig/clk/control). It decodes line and frame timing and recovers 2-bit pixels, then emits one framebuffer write per pixel with x/y coordinates. It sits on the capture side of the upscaler, ahead of the framebuffer writer. It is also the loopback checker for our LCD controller output.
- All bus inputs are synchronous to clk_8m.
- A bus clk high phase is one or more clk_8m cycles, as our generator produces.

Parameters:
H_PIXELS, 160, pixels per active line; pixels beyond this are dropped.
V_LINES, 144, active lines per frame; lines beyond this are dropped.

Ports:
clk_8m  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
lcd_d0  in  1  pixel data bit 0, inverted on the wire.
lcd_d1  in  1  pixel data bit 1, inverted on the wire.
lcd_hsync  in  1  line sync.
lcd_vsync  in  1  frame sync; high across the first line's hsync.
lcd_datal  in  1  end-of-line latch pulse.
lcd_altsig  in  1  line alternation (polarity) signal.
lcd_clk  in  1  pixel shift clock.
pix_we  out  1  one-cycle write strobe.
pix_x  out  8  pixel column, 0..H_PIXELS-1.
pix_y  out  8  pixel row, 0..V_LINES-1.
pix_data  out  2  recovered pixel, equal to {~d1,~d0}.
frame_start  out  1  one-cycle pulse at each detected frame start.
locked  out  1  high once one complete, error-free frame has been received.
err_flags  out  4  sticky: [0] overrun (x≥H_PIXELS), [1] short line, [2] extra lines, [3] altsig did not toggle.
err_clr  in  1  clears err_flags.

Behaviour:
- Input stage: register all lcd_* inputs once, then keep a second copy of clk, hsync and datal for edge detection. An edge is detected when the current registered value differs from the previous one.
- Reset: pix_we=0, pix_x=0, pix_y=0, pix_data=0, frame_start=0, locked=0, err_flags=0; FSM goes to SEARCH.
- FSM states:
  - SEARCH: wait for an hsync rising edge with registered vsync=1. Then y=0, x=0, pulse frame_start, go to ACTIVE.
  - ACTIVE: capture pixels, one per clk rising edge while registered hsync=0. A datal rising edge goes to LINE_END.
  - LINE_END: run the end-of-line checks, then go to WAIT_LINE.
  - WAIT_LINE: an hsync rising edge with vsync=0 gives y=y+1, x=0, then ACTIVE. An hsync rising edge with vsync=1 is a frame start: y=0, then ACTIVE.
- Ignored edges:
  - clk rising edges while hsync=1 (the hsync-embedded shift pulse).
  - All clk edges in SEARCH and WAIT_LINE.
- Pixel capture:
  - pix_data={~d1,~d0}, using data registered on the same cycle as the clk sample.
  - pix_x=x, then x increments.
  - pix_we is high exactly 2 clk_8m cycles after the first cycle lcd_clk is high at the port, for one cycle.
  - If x≥H_PIXELS or y≥V_LINES: no write; set err[0] (x overrun) or err[2] (y overrun). x saturates at 255.
- End-of-line checks (LINE_END):
  - x<H_PIXELS and y<V_LINES: set err[1].
  - altsig equal to the previous line's sampled value: set err[3]. The first line of a frame is exempt.
- locked:
  - Set at the frame start that follows a frame with exactly V_LINES lines and no new errors.
  - Cleared at a frame start whose previous frame had an error or a line count ≠ V_LINES.
  - Cleared by rst.
- Frame start in any state (other than SEARCH) re-synchronises: y=0, x=0, frame_start pulse.
- Simultaneous events:
  - datal and hsync rising on the same cycle: do the LINE_END checks first, then apply the hsync action in the same cycle.
  - err_clr and a new error on the same cycle: the error wins.
- control is not an input and is not decoded.

Decomposition:
- Shared package dmg_lcd_pkg holds:
  - Timing constants: H_PIXELS, V_LINES.
  - Error bit indices: ERR_OVERRUN, ERR_SHORT, ERR_VEXTRA, ERR_ALT.
  - FSM state typedef.
- One natural sub-module: dmg_lcd_rx_sync. It holds the input register plus edge detect and outputs clk_rise, hsync_rise, datal_rise and the registered data.

Test Plan:
- Loopback from the controller with data_in fed as pixel (x^y)&3, 2 frames -> 23040 writes per frame, each pix_data=(x^y)&3, first write x=0,y=0, frame_start twice, locked=1 after frame 2 start, err_flags=0.
- Line with 163 clk pulses -> 160 writes, err[0]=1, no write with x≥160.
- Line with 100 clk pulses then datal -> err[1]=1; the next line still begins with x=0 and y incremented.
- Frame with 146 lines -> y=144,145 produce no writes, err[2]=1, locked drops at the next frame start.
- altsig held constant for 2 lines -> err[3]=1; err_clr for 1 cycle clears it to 0.
- rst asserted mid-line (x=50) -> next cycle all outputs 0, no writes until the next vsync-qualified hsync, and the first write after that is x=0,y=0.

Source files
------------

// File: rtl/dmg_lcd_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : dmg_lcd_pkg                                                     |
// | Purpose   : Shared constants, error bit indices and FSM state type for the  |
// |             DMG LCD bus receiver.                                           |
// | Contents  : H_PIXELS / V_LINES  - default active frame geometry             |
// |             ERR_*               - bit positions inside err_flags            |
// |             rx_state_t          - receiver FSM states                       |
// |             sat_inc()           - 8-bit increment that sticks at 255        |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dmg_lcd_pkg;

  localparam logic [7:0] H_PIXELS = 8'd160;
  localparam logic [7:0] V_LINES  = 8'd144;

  localparam int ERR_OVERRUN = 0;
  localparam int ERR_SHORT   = 1;
  localparam int ERR_VEXTRA  = 2;
  localparam int ERR_ALT     = 3;
  localparam int ERR_W       = 4;

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    ACTIVE    = 2'd1,
    LINE_END  = 2'd2,
    WAIT_LINE = 2'd3
  } rx_state_t;

  // Coordinates never wrap: a runaway line or frame pins at 255 so an
  // overrun can never alias back onto a valid pixel position.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmg_lcd_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : dmg_lcd_rx_if                                                   |
// | Purpose   : DMG LCD panel bus as seen by the capture side.                  |
// | Signals   : d0, d1  - pixel data bits (inverted on the wire)                |
// |             hsync   - line sync          vsync  - frame sync                |
// |             datal   - end-of-line latch  altsig - line alternation          |
// |             clk     - pixel shift clock                                     |
// | Modports  : master - LCD controller / generator (drives the bus)            |
// |             slave  - receiver (samples the bus)                             |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dmg_lcd_rx_if;

  logic d0;
  logic d1;
  logic hsync;
  logic vsync;
  logic datal;
  logic altsig;
  logic clk;

  modport master (output d0, d1, hsync, vsync, datal, altsig, clk);
  modport slave  (input  d0, d1, hsync, vsync, datal, altsig, clk);

endinterface
`default_nettype wire

// File: rtl/dmg_lcd_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : dmg_lcd_rx_sync                                                 |
// | Purpose   : Registers every LCD bus input once and detects rising edges of  |
// |             the shift clock, hsync and datal.                               |
// | Ports     : clk_8m, rst           - system clock, sync active-high reset    |
// |             lcd                   - LCD bus (slave side)                    |
// |             d0_q..altsig_q        - registered bus levels                   |
// |             clk_rise, hsync_rise,                                           |
// |             datal_rise            - one-cycle rising-edge flags             |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmg_lcd_rx_sync (
  input  logic        clk_8m,
  input  logic        rst,
  dmg_lcd_rx_if.slave lcd,
  output logic        d0_q,
  output logic        d1_q,
  output logic        hsync_q,
  output logic        vsync_q,
  output logic        altsig_q,
  output logic        clk_rise,
  output logic        hsync_rise,
  output logic        datal_rise
);

  logic clk_q;
  logic clk_p;
  logic hsync_p;
  logic datal_q;
  logic datal_p;

  // Data and shift clock share one register stage, so the data seen on a
  // detected clock edge is the data present on the wire with that clock.
  always_ff @(posedge clk_8m) begin
    if (rst) begin
      d0_q     <= 1'b0;
      d1_q     <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      altsig_q <= 1'b0;
      datal_q  <= 1'b0;
      clk_q    <= 1'b0;
      clk_p    <= 1'b0;
      hsync_p  <= 1'b0;
      datal_p  <= 1'b0;
    end else begin
      d0_q     <= lcd.d0;
      d1_q     <= lcd.d1;
      hsync_q  <= lcd.hsync;
      vsync_q  <= lcd.vsync;
      altsig_q <= lcd.altsig;
      datal_q  <= lcd.datal;
      clk_q    <= lcd.clk;
      clk_p    <= clk_q;
      hsync_p  <= hsync_q;
      datal_p  <= datal_q;
    end
  end

  assign clk_rise   = clk_q   & ~clk_p;
  assign hsync_rise = hsync_q & ~hsync_p;
  assign datal_rise = datal_q & ~datal_p;

endmodule
`default_nettype wire

// File: rtl/dmg_lcd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : dmg_lcd_rx                                                      |
// | Purpose   : DMG LCD bus receiver. Recovers line/frame timing and 2-bit      |
// |             pixels and emits one framebuffer write per active pixel.        |
// | Ports     : clk_8m, rst    - system clock, sync active-high reset           |
// |             lcd            - LCD panel bus (slave side)                     |
// |             err_clr        - clears the sticky error flags                  |
// |             pix_we         - one-cycle pixel write strobe                   |
// |             pix_x, pix_y   - pixel column / row                             |
// |             pix_data       - recovered pixel {~d1,~d0}                      |
// |             frame_start    - one-cycle pulse per detected frame start       |
// |             locked         - a full, error-free frame has been received     |
// |             err_flags      - sticky {alt, vextra, short, overrun}           |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmg_lcd_rx #(
  parameter logic [7:0] H_PIXELS = dmg_lcd_pkg::H_PIXELS,
  parameter logic [7:0] V_LINES  = dmg_lcd_pkg::V_LINES
) (
  input  logic        clk_8m,
  input  logic        rst,
  dmg_lcd_rx_if.slave lcd,
  input  logic        err_clr,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic [1:0]  pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic [3:0]  err_flags
);

  import dmg_lcd_pkg::*;

  logic bus_d0, bus_d1, bus_hsync, bus_vsync, bus_altsig;
  logic clk_rise, hsync_rise, datal_rise;

  dmg_lcd_rx_sync u_sync (
    .clk_8m     (clk_8m),
    .rst        (rst),
    .lcd        (lcd),
    .d0_q       (bus_d0),
    .d1_q       (bus_d1),
    .hsync_q    (bus_hsync),
    .vsync_q    (bus_vsync),
    .altsig_q   (bus_altsig),
    .clk_rise   (clk_rise),
    .hsync_rise (hsync_rise),
    .datal_rise (datal_rise)
  );

  rx_state_t  state, state_n;
  logic [7:0] x, x_n, y, y_n;
  logic       alt_prev, alt_prev_n;
  logic       alt_valid, alt_valid_n;   // a previous line of this frame exists
  logic       frame_err, frame_err_n;   // any error raised in the current frame
  logic       in_frame, in_frame_n;     // a frame has started since reset
  logic       locked_n;
  logic       we_n, fs_n;
  logic [7:0] px_n, py_n;
  logic [1:0] pd_n;
  logic [ERR_W-1:0] new_err;
  logic [ERR_W-1:0] err_n;

  logic capture, do_eol, frame_sync, line_sync, frame_err_any;

  // Shift pulses during hsync are the embedded pulse, never a pixel.
  assign capture    = (state == ACTIVE) && clk_rise && !bus_hsync;
  // End-of-line checks run in LINE_END, or immediately when datal and hsync
  // rise together so the hsync action can still be applied this cycle.
  assign do_eol     = (state == LINE_END) ||
                      ((state == ACTIVE) && datal_rise && hsync_rise);
  assign frame_sync = hsync_rise && bus_vsync && (state inside {SEARCH, ACTIVE, LINE_END, WAIT_LINE});
  assign line_sync  = hsync_rise && !bus_vsync &&
                      ((state == WAIT_LINE) || (state == LINE_END) ||
                       ((state == ACTIVE) && datal_rise));
  assign frame_err_any = frame_err | (|new_err);
  // A new error always wins over a simultaneous clear.
  assign err_n = (err_clr ? '0 : err_flags) | new_err;

  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    alt_prev_n  = alt_prev;
    alt_valid_n = alt_valid;
    frame_err_n = frame_err_any;
    in_frame_n  = in_frame;
    locked_n    = locked;
    we_n        = 1'b0;
    fs_n        = 1'b0;
    px_n        = pix_x;
    py_n        = pix_y;
    pd_n        = pix_data;
    new_err     = '0;

    if (capture) begin
      if ((x < H_PIXELS) && (y < V_LINES)) begin
        we_n = 1'b1;
        px_n = x;
        py_n = y;
        pd_n = {~bus_d1, ~bus_d0};
      end
      if (x >= H_PIXELS) new_err[ERR_OVERRUN] = 1'b1;
      if (y >= V_LINES)  new_err[ERR_VEXTRA]  = 1'b1;
      x_n = sat_inc(x);
    end

    if (do_eol) begin
      // Lines past the frame end are already flagged; no short check there.
      if ((x < H_PIXELS) && (y < V_LINES)) new_err[ERR_SHORT] = 1'b1;
      if (alt_valid && (bus_altsig == alt_prev)) new_err[ERR_ALT] = 1'b1;
      alt_prev_n  = bus_altsig;
      alt_valid_n = 1'b1;
    end

    case (state)
      SEARCH:    ;
      ACTIVE:    if (datal_rise && !hsync_rise) state_n = LINE_END;
      LINE_END:  state_n = WAIT_LINE;
      WAIT_LINE: ;
      default:   state_n = SEARCH;
    endcase

    if (frame_sync) begin
      // The verdict on the finished frame includes errors raised this cycle.
      if (in_frame) locked_n = (y == V_LINES - 8'd1) && !frame_err_any;
      state_n     = ACTIVE;
      x_n         = '0;
      y_n         = '0;
      fs_n        = 1'b1;
      alt_valid_n = 1'b0;
      frame_err_n = 1'b0;
      in_frame_n  = 1'b1;
    end else if (line_sync) begin
      state_n = ACTIVE;
      x_n     = '0;
      y_n     = sat_inc(y);
    end
  end

  always_ff @(posedge clk_8m) begin
    if (rst) begin
      state       <= SEARCH;
      x           <= '0;
      y           <= '0;
      alt_prev    <= 1'b0;
      alt_valid   <= 1'b0;
      frame_err   <= 1'b0;
      in_frame    <= 1'b0;
      locked      <= 1'b0;
      err_flags   <= '0;
      pix_we      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      alt_prev    <= alt_prev_n;
      alt_valid   <= alt_valid_n;
      frame_err   <= frame_err_n;
      in_frame    <= in_frame_n;
      locked      <= locked_n;
      err_flags   <= err_n;
      pix_we      <= we_n;
      pix_x       <= px_n;
      pix_y       <= py_n;
      pix_data    <= pd_n;
      frame_start <= fs_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmg_lcd_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_dmg_lcd_rx                                                   |
// | Purpose   : Directed self-checking bench for dmg_lcd_rx. A small bus        |
// |             generator drives lines/frames; every expected pixel write       |
// |             (cycle, x, y, data) is queued by the generator and matched by a |
// |             write monitor. A shortened frame height keeps run time low.     |
// | Revision  : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmg_lcd_rx;

  localparam logic [7:0] H = 8'd160;
  localparam logic [7:0] V = 8'd6;

  logic       clk_8m = 1'b0;
  logic       rst;
  logic       err_clr;
  logic       pix_we;
  logic [7:0] pix_x, pix_y;
  logic [1:0] pix_data;
  logic       frame_start, locked;
  logic [3:0] err_flags;

  dmg_lcd_rx_if lcd_bus ();

  dmg_lcd_rx #(.H_PIXELS(H), .V_LINES(V)) dut (
    .clk_8m      (clk_8m),
    .rst         (rst),
    .lcd         (lcd_bus),
    .err_clr     (err_clr),
    .pix_we      (pix_we),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .locked      (locked),
    .err_flags   (err_flags)
  );

  always #5 clk_8m = ~clk_8m;

  int unsigned cyc = 0;
  always @(posedge clk_8m) cyc <= cyc + 32'd1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Expected writes: {14'b0, cycle, x, y, data}
  logic [63:0] exp_q[$];
  int wr_cnt   = 0;
  int extra_wr = 0;
  int fs_cnt   = 0;

  always @(negedge clk_8m) begin
    if (frame_start) fs_cnt++;
    if (pix_we) begin
      wr_cnt++;
      if (exp_q.size() > 0) check("wr", {14'd0, 32'(cyc), pix_x, pix_y, pix_data}, exp_q.pop_front());
      else extra_wr++;
    end
  end

  task automatic step();
    @(posedge clk_8m);
    #1;
  endtask

  bit alt_v = 1'b0;

  // hsync (with vsync across it for a frame start) carrying one embedded shift pulse
  task automatic line_head(input bit vs, input bit dup_alt);
    lcd_bus.hsync = 1'b1; lcd_bus.vsync = vs; step();
    lcd_bus.clk = 1'b1; step();
    lcd_bus.clk = 1'b0; step();
    lcd_bus.hsync = 1'b0; lcd_bus.vsync = 1'b0;
    if (!dup_alt) alt_v = ~alt_v;
    lcd_bus.altsig = alt_v; step();
  endtask

  task automatic pixels(input int n, input int ypos, input bit expect_wr);
    for (int i = 0; i < n; i++) begin
      logic [1:0] v;
      v = 2'((i ^ ypos) & 3);
      lcd_bus.d0 = ~v[0]; lcd_bus.d1 = ~v[1]; lcd_bus.clk = 1'b1;
      if (expect_wr && (i < int'(H)) && (ypos < int'(V)))
        exp_q.push_back({14'd0, cyc + 32'd2, 8'(i), 8'(ypos), v});
      step();
      lcd_bus.clk = 1'b0; step();
    end
  endtask

  task automatic line_tail();
    lcd_bus.datal = 1'b1; step();
    lcd_bus.datal = 1'b0; step();
    step();
  endtask

  task automatic frame(input int nlines);
    for (int l = 0; l < nlines; l++) begin
      line_head(l == 0, 1'b0);
      pixels(int'(H), l, 1'b1);
      line_tail();
    end
  endtask

  task automatic clear_errors();
    err_clr = 1'b1; step();
    err_clr = 1'b0; step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_we"},     pix_we,      0);
    check({tag, "_x"},      pix_x,       0);
    check({tag, "_y"},      pix_y,       0);
    check({tag, "_data"},   pix_data,    0);
    check({tag, "_fs"},     frame_start, 0);
    check({tag, "_locked"}, locked,      0);
    check({tag, "_err"},    err_flags,   0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    lcd_bus.d0 = 1'b1; lcd_bus.d1 = 1'b1; lcd_bus.hsync = 1'b0; lcd_bus.vsync = 1'b0;
    lcd_bus.datal = 1'b0; lcd_bus.altsig = 1'b0; lcd_bus.clk = 1'b0;
    rst = 1'b1; err_clr = 1'b0;
    step(); step(); step();
    @(negedge clk_8m);
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Two clean frames: locked only after the second frame start
    frame(int'(V));
    check("locked_f1", locked, 0);
    frame(int'(V));
    check("locked_f2", locked, 1);
    check("wr_cnt_2f", wr_cnt, 2 * int'(H) * int'(V));
    check("fs_cnt_2f", fs_cnt, 2);
    check("err_2f", err_flags, 0);
    check("q_2f", exp_q.size(), 0);

    // Frame 3: overrun, short line, altsig stuck
    line_head(1'b1, 1'b0); pixels(int'(H) + 3, 0, 1'b1); line_tail();
    check("err_overrun", err_flags, 4'b0001);
    check("extra_overrun", extra_wr, 0);
    line_head(1'b0, 1'b0); pixels(100, 1, 1'b1); line_tail();
    check("err_short", err_flags, 4'b0011);
    clear_errors();
    check("err_clr1", err_flags, 0);
    line_head(1'b0, 1'b0); pixels(int'(H), 2, 1'b1); line_tail();
    check("err_after_short", err_flags, 0);
    line_head(1'b0, 1'b1); pixels(int'(H), 3, 1'b1); line_tail();
    check("err_alt", err_flags, 4'b1000);
    clear_errors();
    check("err_clr2", err_flags, 0);
    line_head(1'b0, 1'b0); pixels(int'(H), 4, 1'b1); line_tail();
    line_head(1'b0, 1'b0); pixels(int'(H), 5, 1'b1); line_tail();
    check("q_f3", exp_q.size(), 0);
    check("locked_f3", locked, 1);

    // Frame 4 clean, but frame 3 had errors
    frame(int'(V));
    check("locked_f4", locked, 0);
    check("fs_cnt_f4", fs_cnt, 4);

    // Frame 5: reset in the middle of line 0
    line_head(1'b1, 1'b0);
    check("locked_f5", locked, 1);
    pixels(50, 0, 1'b1);
    step();
    check("pre_rst_x", pix_x, 49);
    rst = 1'b1; step();
    @(negedge clk_8m);
    check_outputs_zero("midrst");
    rst = 1'b0;
    pixels(20, 0, 1'b0); line_tail();
    line_head(1'b0, 1'b0); pixels(10, 1, 1'b0); line_tail();
    check("extra_after_rst", extra_wr, 0);
    check("fs_after_rst", fs_cnt, 5);

    // Frame A after reset: writes restart at x=0,y=0
    frame(int'(V));
    check("fs_cnt_a", fs_cnt, 6);
    check("locked_a", locked, 0);
    check("q_a", exp_q.size(), 0);

    // Frame B with two extra lines
    frame(int'(V) + 2);
    check("locked_b", locked, 1);
    check("err_vextra", err_flags, 4'b0100);
    check("extra_b", extra_wr, 0);

    // Frame C start drops lock
    line_head(1'b1, 1'b0);
    check("locked_c", locked, 0);
    check("fs_cnt_c", fs_cnt, 8);
    pixels(int'(H), 0, 1'b1); line_tail();
    check("q_end", exp_q.size(), 0);
    check("extra_end", extra_wr, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
